mem_stream_reader: RTL



---
 rtl/mem_stream_reader.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_stream_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_stream_reader
//
// Avalon-MM read master that fetches a contiguous packet buffer from the main
// memory and emits it as an Avalon-ST packet. A command gives the first word
// address and a byte length. The block issues pipelined single-word reads
// against a fixed-latency slave port. It buffers the returned words in a small
// FIFO and frames them with sop/eop/empty under sink backpressure.
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o command handshake (ready only while idle)
//   cmd_address_i           first word address of the buffer
//   cmd_length_i            packet length in bytes
//   mem_address_o           read word address
//   mem_chipselect_o        read strobe, one word per high cycle
//   mem_write_o             always 0
//   mem_byteenable_o        always 4'hF
//   mem_readdata_i          read data, READ_LATENCY cycles after its strobe
//   st_data_o               stream data, byte 0 in [31:24]
//   st_valid_o, st_ready_i  stream handshake
//   st_startofpacket_o      first beat marker
//   st_endofpacket_o        last beat marker
//   st_empty_o              unused bytes on the eop beat
//   busy_o                  high while a packet is in progress
//   done_o                  one-cycle pulse after the packet completes
// -----------------------------------------------------------------------------
module mem_stream_reader #(
    parameter int ADDR_W       = 17,
    parameter int LEN_W        = 16,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_address_i,
    input  logic [LEN_W-1:0]  cmd_length_i,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic              mem_chipselect_o,
    output logic              mem_write_o,
    output logic [3:0]        mem_byteenable_o,
    input  logic [31:0]       mem_readdata_i,
    output logic [31:0]       st_data_o,
    output logic              st_valid_o,
    input  logic              st_ready_i,
    output logic              st_startofpacket_o,
    output logic              st_endofpacket_o,
    output logic [1:0]        st_empty_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WORDS_W = LEN_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [WORDS_W-1:0]      wordsLeft_q, wordsLeft_d;
    logic [WORDS_W-1:0]      beatsLeft_q, beatsLeft_d;
    logic [1:0]              lastEmpty_q, lastEmpty_d;
    logic                    firstBeat_q, firstBeat_d;
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
    logic [READ_LATENCY-1:0] rdValid_q, rdValid_d;
    logic                    done_q, done_d;
    logic [31:0]             fifoMem_q [FIFO_DEPTH];

    logic                    cmdAccept;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    eopBeat;
    logic [CNT_W:0]          credits;
    logic [WORDS_W-1:0]      cmdWords;

    // Next-state logic. A read is only issued while the words already
    // buffered plus the words still in flight leave room in the FIFO.
    // Returned data therefore always has a free slot and is never stalled.
    always_comb begin
        cmdAccept = cmd_valid_i && (state_q == IDLE);
        cmdWords  = {1'b0, cmd_length_i[LEN_W-1:2]} + WORDS_W'(cmd_length_i[1:0] != 2'b00);
        credits   = {1'b0, count_q} + {1'b0, inflight_q};
        issue     = (state_q == RUN) && (wordsLeft_q != '0)
                    && (credits < (CNT_W+1)'(FIFO_DEPTH));
        push      = rdValid_q[READ_LATENCY-1];
        pop       = (count_q != '0) && st_ready_i;
        eopBeat   = pop && (beatsLeft_q == WORDS_W'(1));

        state_d     = state_q;
        addr_d      = addr_q;
        wordsLeft_d = wordsLeft_q;
        beatsLeft_d = beatsLeft_q;
        lastEmpty_d = lastEmpty_q;
        firstBeat_d = firstBeat_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        done_d      = 1'b0;

        // The valid pipeline delays each strobe by the slave latency.
        // Its last stage marks the cycle the read data is on the bus.
        rdValid_d  = READ_LATENCY'({rdValid_q, issue});
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d     = rdPtr_q + PTR_W'(1);
            beatsLeft_d = beatsLeft_q - WORDS_W'(1);
            firstBeat_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmdAccept) begin
                    if (cmd_length_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d      = cmd_address_i;
                        wordsLeft_d = cmdWords;
                        beatsLeft_d = cmdWords;
                        lastEmpty_d = 2'(3'd4 - {1'b0, cmd_length_i[1:0]});
                        firstBeat_d = 1'b1;
                        state_d     = RUN;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d      = addr_q + ADDR_W'(1);
                    wordsLeft_d = wordsLeft_q - WORDS_W'(1);
                    if (wordsLeft_q == WORDS_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (eopBeat) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state register. Reset drops all in-flight tracking, so any
    // response to a read issued before reset is ignored.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wordsLeft_q <= '0;
            beatsLeft_q <= '0;
            lastEmpty_q <= '0;
            firstBeat_q <= 1'b0;
            inflight_q  <= '0;
            count_q     <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            rdValid_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wordsLeft_q <= wordsLeft_d;
            beatsLeft_q <= beatsLeft_d;
            lastEmpty_q <= lastEmpty_d;
            firstBeat_q <= firstBeat_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            rdValid_q   <= rdValid_d;
            done_q      <= done_d;
        end
    end

    // FIFO storage needs no reset. The pointers and count define which
    // entries are live, and st_data is gated while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= mem_readdata_i;
        end
    end

    assign cmd_ready_o        = (state_q == IDLE) && !reset_i;
    assign busy_o             = (state_q != IDLE);
    assign done_o             = done_q;
    assign mem_address_o      = addr_q;
    assign mem_chipselect_o   = issue;
    assign mem_write_o        = 1'b0;
    assign mem_byteenable_o   = 4'hF;
    assign st_valid_o         = (count_q != '0);
    assign st_data_o          = st_valid_o ? fifoMem_q[rdPtr_q] : 32'h0;
    assign st_startofpacket_o = st_valid_o && firstBeat_q;
    assign st_endofpacket_o   = st_valid_o && (beatsLeft_q == WORDS_W'(1));
    assign st_empty_o         = st_endofpacket_o ? lastEmpty_q : 2'b00;

endmodule
